// File: rtl/key_ev_pkg.sv
// Shared types and helpers for the key event front-end.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package key_ev_pkg;

    localparam int NOTE_W = 7;
    localparam int EV_W   = 8;

    // One queued keyboard event: note-on/off flag plus MIDI note number.
    typedef struct packed {
        logic              on;
        logic [NOTE_W-1:0] note;
    } key_ev_t;

    // Clamp a signed note computation into the MIDI range 0..127.
    function automatic logic [NOTE_W-1:0] clamp_note(input int v);
        if (v < 0) begin
            return '0;
        end else if (v > 127) begin
            return 7'd127;
        end else begin
            return NOTE_W'(v);
        end
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw line.
// Latency: raw change to o_level change is 2 + DBC_COUNT + 1 cycles.
// Backpressure: none; o_edge pulses for one cycle just before o_level flips.
module key_debounce #(
    parameter int DBC_COUNT = 255,
    parameter int DBC_W     = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_edge
);

    localparam logic [DBC_W-1:0] CNT_MAX = DBC_W'(DBC_COUNT);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [DBC_W-1:0] r_cnt;
    logic             w_done;

    assign w_done = (r_cnt == CNT_MAX);

    // Synchronise the raw line; count cycles the synced level disagrees with the stable level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
            if (r_s2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_stable <= r_s2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_stable;
    // High in the cycle whose closing edge flips the stable level.
    assign o_edge  = w_done & (r_s2 != r_stable);

endmodule

// File: rtl/key_event_frontend.sv
// Keyboard front-end: debounce keys and pitch buttons, turn key edges into note events, queue them (optional sustain via KEY_SUSTAIN_EN).
// Latency: raw press to keys_down 2+DBC_COUNT+1 cycles; keys_down to ev_valid 1 cycle when the FIFO has room.
// Backpressure: ev_ready low fills the FIFO; further edges stay pending per key and are never dropped.
module key_event_frontend
    import key_ev_pkg::*;
#(
    parameter int N_KEYS     = 10,
    parameter int DBC_COUNT  = 255,
    parameter int DBC_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int BASE_NOTE  = 60,
    parameter int SHIFT_MAX  = 12
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_KEYS-1:0]             i_key_raw,
    input  logic                          i_pitch_up,
    input  logic                          i_pitch_down,
    input  logic                          i_sustain,
    output logic                          o_ev_valid,
    input  logic                          i_ev_ready,
    output logic                          o_ev_on,
    output logic [NOTE_W-1:0]             o_ev_note,
    output logic signed [4:0]             o_pitch_offset,
    output logic [N_KEYS-1:0]             o_keys_down,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int N_LINES = N_KEYS + 2;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic signed [4:0] OFF_MAX = 5'(SHIFT_MAX);
    localparam logic signed [4:0] OFF_MIN = -OFF_MAX;

    logic [N_LINES-1:0] w_raw;
    logic [N_LINES-1:0] w_level;
    logic [N_LINES-1:0] w_edge;
    logic [N_KEYS-1:0]  w_keys;
    logic [N_KEYS-1:0]  w_key_edge;
    logic               w_up_rise;
    logic               w_dn_rise;

    logic signed [4:0]  r_offset;
    logic [N_KEYS-1:0]  r_pending;
    logic [N_KEYS-1:0]  w_pend_nxt;
    logic [NOTE_W-1:0]  r_note_lat [N_KEYS];

    logic               w_found;
    logic [N_KEYS-1:0]  w_sel;
    logic [N_KEYS-1:0]  w_push_clr;
    key_ev_t            w_ev;
    logic               w_push;
    logic               w_pop;
    logic               w_full;

    key_ev_t            r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_level;
    key_ev_t            w_head;

    // Keys occupy the low lines, pitch up/down the two top lines.
    assign w_raw = {i_pitch_down, i_pitch_up, i_key_raw};

    for (genvar g = 0; g < N_LINES; g++) begin : g_dbc
        key_debounce #(
            .DBC_COUNT (DBC_COUNT),
            .DBC_W     (DBC_W)
        ) u_dbc (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_raw   (w_raw[g]),
            .o_level (w_level[g]),
            .o_edge  (w_edge[g])
        );
    end

    assign w_keys     = w_level[N_KEYS-1:0];
    assign w_key_edge = w_edge[N_KEYS-1:0];
    assign w_up_rise  = w_edge[N_KEYS]   & ~w_level[N_KEYS];
    assign w_dn_rise  = w_edge[N_KEYS+1] & ~w_level[N_KEYS+1];

`ifdef KEY_SUSTAIN_EN
    logic              r_sus_s1;
    logic              r_sus;
    logic              r_sus_d;
    logic              w_sus_fall;
    logic [N_KEYS-1:0] r_hold;
    logic [N_KEYS-1:0] w_hold_nxt;

    // Synchronise the pedal and track keys whose release is being held off.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sus_s1 <= 1'b0;
            r_sus    <= 1'b0;
            r_sus_d  <= 1'b0;
            r_hold   <= '0;
        end else begin
            r_sus_s1 <= i_sustain;
            r_sus    <= r_sus_s1;
            r_sus_d  <= r_sus;
            r_hold   <= w_hold_nxt;
        end
    end

    assign w_sus_fall = r_sus_d & ~r_sus;
`else
    logic w_unused_sustain;
    assign w_unused_sustain = i_sustain;
`endif

    // Transpose: one semitone per debounced rising edge, saturating, both at once cancel.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_offset <= '0;
        end else if (w_up_rise && !w_dn_rise && (r_offset != OFF_MAX)) begin
            r_offset <= r_offset + 5'sd1;
        end else if (w_dn_rise && !w_up_rise && (r_offset != OFF_MIN)) begin
            r_offset <= r_offset - 5'sd1;
        end
    end

    // Scanner: pick the lowest pending key and build its event.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_ev    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            if (r_pending[i] && !w_found) begin
                w_found  = 1'b1;
                w_sel[i] = 1'b1;
                w_ev.on  = w_keys[i];
                w_ev.note = w_keys[i] ? clamp_note(BASE_NOTE + i + int'($signed(r_offset)))
                                      : r_note_lat[i];
            end
        end
    end

    assign w_full     = (r_level == (AW+1)'(FIFO_DEPTH));
    assign w_push     = w_found & ~w_full;
    assign w_push_clr = w_push ? w_sel : '0;
    assign w_pop      = o_ev_valid & i_ev_ready;

    // Pending bits: the push clears one, each stable edge toggles one so press+release annihilate.
    always_comb begin
        w_pend_nxt = r_pending & ~w_push_clr;
`ifdef KEY_SUSTAIN_EN
        w_hold_nxt = r_hold;
`endif
        for (int i = 0; i < N_KEYS; i++) begin
            if (w_key_edge[i]) begin
`ifdef KEY_SUSTAIN_EN
                if (w_keys[i] && r_sus) begin
                    // Release under sustain: cancel an unsent note-on, otherwise hold the note.
                    if (w_pend_nxt[i]) begin
                        w_pend_nxt[i] = 1'b0;
                    end else begin
                        w_hold_nxt[i] = 1'b1;
                    end
                end else if (!w_keys[i] && w_hold_nxt[i]) begin
                    // Re-press of a held key retriggers with a fresh note-on.
                    w_hold_nxt[i] = 1'b0;
                    w_pend_nxt[i] = 1'b1;
                end else begin
                    w_pend_nxt[i] = ~w_pend_nxt[i];
                end
`else
                w_pend_nxt[i] = ~w_pend_nxt[i];
`endif
            end
        end
`ifdef KEY_SUSTAIN_EN
        if (w_sus_fall) begin
            w_pend_nxt = w_pend_nxt | w_hold_nxt;
            w_hold_nxt = '0;
        end
`endif
    end

    // Register pending bits and latch the note of every emitted note-on.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                r_note_lat[i] <= '0;
            end
        end else begin
            r_pending <= w_pend_nxt;
            for (int i = 0; i < N_KEYS; i++) begin
                if (w_push_clr[i] && w_ev.on) begin
                    r_note_lat[i] <= w_ev.note;
                end
            end
        end
    end

    // Event FIFO storage; contents are don't-care while the level says empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_ev;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign w_head         = r_mem[r_rd_ptr];
    assign o_ev_valid     = (r_level != '0);
    assign o_ev_on        = o_ev_valid & w_head.on;
    assign o_ev_note      = o_ev_valid ? w_head.note : '0;
    assign o_pitch_offset = r_offset;
    assign o_keys_down    = w_keys;
    assign o_fifo_level   = r_level;

endmodule

// File: tb/tb_key_event_frontend.sv
// Directed bench for key_event_frontend with a short debounce count.
// Latency: press to keys_down is DC+3 cycles at these parameters.
// Backpressure: ev_ready is held high except in the FIFO-fill sequence.
module tb_key_event_frontend;

    localparam int NK = 10;
    localparam int DC = 15;
    localparam int DW = 4;
    localparam int FD = 8;
    localparam int L  = DC + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_raw = '0;
    logic          up = 1'b0;
    logic          dn = 1'b0;
    logic          sus = 1'b0;
    logic          ready = 1'b1;
    logic          ev_valid;
    logic          ev_on;
    logic [6:0]    ev_note;
    logic signed [4:0] pitch_offset;
    logic [NK-1:0] keys_down;
    logic [3:0]    fifo_level;

    int checks = 0;
    int failures = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [NK-1:0]   keys;
        logic [NK-1:0]   down;
        int              n_ev;
        logic [2:0][7:0] ev;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    key_event_frontend #(
        .N_KEYS(NK), .DBC_COUNT(DC), .DBC_W(DW),
        .FIFO_DEPTH(FD), .BASE_NOTE(60), .SHIFT_MAX(12)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_key_raw(key_raw),
        .i_pitch_up(up), .i_pitch_down(dn), .i_sustain(sus),
        .o_ev_valid(ev_valid), .i_ev_ready(ready),
        .o_ev_on(ev_on), .o_ev_note(ev_note),
        .o_pitch_offset(pitch_offset), .o_keys_down(keys_down),
        .o_fifo_level(fifo_level)
    );

    // Record every accepted event, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && ev_valid && ready) q.push_back({ev_on, ev_note});
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] evc(input logic on, input int note);
        return {on, 7'(note)};
    endfunction

    function automatic vec_t mkvec(input logic [NK-1:0] k, input int n, input logic [2:0][7:0] e);
        vec_t v;
        v.keys = k;
        v.down = k;
        v.n_ev = n;
        v.ev   = e;
        return v;
    endfunction

    task automatic check_q(input string nm, input int n, input logic [2:0][7:0] e);
        chk({nm, "_count"}, q.size(), n);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_ev%0d", nm, k), (k < q.size()) ? int'(q[k]) : -1, int'(e[k]));
        end
    endtask

    task automatic pulse_pitch(input logic u, input logic d);
        up = u;
        dn = d;
        tick(25);
        up = 1'b0;
        dn = 1'b0;
        tick(25);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0] = mkvec(10'h008, 1, {8'h00, 8'h00, evc(1, 63)});
        vecs[1] = mkvec(10'h000, 1, {8'h00, 8'h00, evc(0, 63)});
        vecs[2] = mkvec(10'h222, 3, {evc(1, 69), evc(1, 65), evc(1, 61)});
        vecs[3] = mkvec(10'h000, 3, {evc(0, 69), evc(0, 65), evc(0, 61)});
        vecs[4] = mkvec(10'h201, 2, {8'h00, evc(1, 69), evc(1, 60)});
        vecs[5] = mkvec(10'h200, 1, {8'h00, 8'h00, evc(0, 60)});
        vecs[6] = mkvec(10'h000, 1, {8'h00, 8'h00, evc(0, 69)});

        // Reset state
        key_raw = 10'h3FF;
        tick(4);
        chk("rst_valid", ev_valid, 0);
        chk("rst_on", ev_on, 0);
        chk("rst_note", ev_note, 0);
        chk("rst_offset", pitch_offset, 0);
        chk("rst_keys", keys_down, 0);
        chk("rst_level", fifo_level, 0);
        key_raw = '0;
        rst = 1'b0;
        tick(30);
        q.delete();

        // Clean press of key 3: exact debounce latency, then one event
        key_raw[3] = 1'b1;
        n = 0;
        while (!keys_down[3] && n < 100) begin
            tick(1);
            n++;
        end
        chk("t1_latency", n, L);
        chk("t1_valid_early", ev_valid, 0);
        tick(1);
        chk("t1_valid", ev_valid, 1);
        chk("t1_on", ev_on, 1);
        chk("t1_note", ev_note, 63);
        key_raw[3] = 1'b0;
        tick(30);
        q.delete();

        // Glitches shorter than the debounce count never register
        key_raw[0] = 1'b1; tick(6);
        key_raw[0] = 1'b0; tick(4);
        key_raw[0] = 1'b1; tick(5);
        key_raw[0] = 1'b0; tick(30);
        chk("t2_keys", keys_down, 0);
        chk("t2_events", q.size(), 0);

        // Table-driven key patterns at zero transpose
        for (int v = 0; v < 7; v++) begin
            q.delete();
            key_raw = vecs[v].keys;
            tick(30);
            chk($sformatf("vec%0d_keys", v), keys_down, vecs[v].down);
            check_q($sformatf("vec%0d", v), vecs[v].n_ev, vecs[v].ev);
        end

        // FIFO fill under backpressure: 10 edges, 8 queued, 2 left pending
        q.delete();
        ready = 1'b0;
        key_raw = 10'h01F;
        tick(30);
        key_raw = '0;
        tick(30);
        chk("t5_level", fifo_level, 8);
        chk("t5_valid", ev_valid, 1);
        chk("t5_head_on", ev_on, 1);
        chk("t5_head_note", ev_note, 60);
        tick(5);
        chk("t5_head_hold", ev_note, 60);
        ready = 1'b1;
        tick(30);
        chk("t5_count", q.size(), 10);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("t5_ev%0d", k), (k < q.size()) ? int'(q[k]) : -1,
                int'((k < 5) ? evc(1, 60 + k) : evc(0, 55 + k)));
        end
        chk("t5_level_end", fifo_level, 0);

        // Sustain pedal around a press/release of key 4
        q.delete();
        sus = 1'b1;
        tick(5);
        key_raw[4] = 1'b1;
        tick(30);
        key_raw[4] = 1'b0;
        tick(30);
`ifdef KEY_SUSTAIN_EN
        check_q("t6_rel", 1, {8'h00, 8'h00, evc(1, 64)});
`else
        check_q("t6_rel", 2, {8'h00, evc(0, 64), evc(1, 64)});
`endif
        q.delete();
        sus = 1'b0;
        tick(10);
`ifdef KEY_SUSTAIN_EN
        check_q("t6_sus", 1, {8'h00, 8'h00, evc(0, 64)});
`else
        check_q("t6_sus", 0, {8'h00, 8'h00, 8'h00});
`endif

        // Transpose saturation and latched note-off
        for (int k = 0; k < 14; k++) pulse_pitch(1'b1, 1'b0);
        chk("t4_offset_sat", pitch_offset, 12);
        q.delete();
        key_raw[2] = 1'b1;
        tick(30);
        check_q("t4_on", 1, {8'h00, 8'h00, evc(1, 74)});
        for (int k = 0; k < 3; k++) pulse_pitch(1'b0, 1'b1);
        chk("t4_offset_down", pitch_offset, 9);
        pulse_pitch(1'b1, 1'b1);
        chk("t4_offset_both", pitch_offset, 9);
        q.delete();
        key_raw[2] = 1'b0;
        tick(30);
        check_q("t4_off", 1, {8'h00, 8'h00, evc(0, 74)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
